// File: rtl/calc_seq_ctrl_v.sv
// Keypad sequencing controller for the two-digit BCD add/subtract calculator.
// Entry registers, latched operation, and a digit-serial add/sub with a B-A fix-up pass.
module calc_seq_ctrl_v #(
    parameter bit CHAIN_EN = 1'b1
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [3:0] disp_ones,
    output logic [3:0] disp_tens,
    output logic       disp_hund,
    output logic       disp_neg,
    output logic       busy,
    output logic       done,
    output logic       key_drop
);
    typedef enum logic [2:0] {
        S_ENTER_A, S_ENTER_B, S_CALC_LO, S_CALC_HI, S_FIX_LO, S_FIX_HI, S_SHOW
    } state_t;

    state_t     state_q;
    logic [7:0] a_q, b_q, res_q;
    logic       op_sub_q, hund_q, neg_q, cw_q;
    logic [3:0] disp_ones_q, disp_tens_q;
    logic       disp_hund_q, disp_neg_q, busy_q, done_q, drop_q, show_seen_q;

    logic [3:0] x_d, y_d, dig_d;
    logic       cin_d, cout_d;
    logic [4:0] sum_d, diff_d, adj_d;

    logic key_digit, key_op, key_eq, key_clr, in_calc;
    assign key_digit = key_valid && (key_code <= 4'd9);
    assign key_op    = key_valid && ((key_code == 4'd10) || (key_code == 4'd11));
    assign key_eq    = key_valid && (key_code == 4'd12);
    assign key_clr   = key_valid && (key_code == 4'd13);
    assign in_calc   = (state_q == S_CALC_LO) || (state_q == S_CALC_HI) ||
                       (state_q == S_FIX_LO)  || (state_q == S_FIX_HI);

    // One digit of the serial datapath; the fix-up pass swaps the operands to form B-A.
    always_comb begin
        x_d   = a_q[3:0];
        y_d   = b_q[3:0];
        cin_d = 1'b0;
        case (state_q)
            S_CALC_HI: begin x_d = a_q[7:4]; y_d = b_q[7:4]; cin_d = cw_q; end
            S_FIX_LO:  begin x_d = b_q[3:0]; y_d = a_q[3:0]; end
            S_FIX_HI:  begin x_d = b_q[7:4]; y_d = a_q[7:4]; cin_d = cw_q; end
            default:   ;
        endcase
        sum_d  = {1'b0, x_d} + {1'b0, y_d} + {4'd0, cin_d};
        diff_d = 5'd10 + {1'b0, x_d} - {1'b0, y_d} - {4'd0, cin_d};
        adj_d  = 5'd0;
        dig_d  = 4'd0;
        cout_d = 1'b0;
        if (op_sub_q) begin
            if (diff_d >= 5'd10) begin
                adj_d  = diff_d - 5'd10;
                dig_d  = adj_d[3:0];
            end else begin
                dig_d  = diff_d[3:0];
                cout_d = 1'b1;
            end
        end else begin
            if (sum_d > 5'd9) begin
                adj_d  = sum_d - 5'd10;
                dig_d  = adj_d[3:0];
                cout_d = 1'b1;
            end else begin
                dig_d  = sum_d[3:0];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR || key_clr) begin
            state_q     <= S_ENTER_A;
            a_q         <= 8'd0;
            b_q         <= 8'd0;
            res_q       <= 8'd0;
            op_sub_q    <= 1'b0;
            hund_q      <= 1'b0;
            neg_q       <= 1'b0;
            cw_q        <= 1'b0;
            disp_ones_q <= 4'd0;
            disp_tens_q <= 4'd0;
            disp_hund_q <= 1'b0;
            disp_neg_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            drop_q      <= 1'b0;
            show_seen_q <= 1'b0;
        end else begin
            busy_q      <= in_calc;
            show_seen_q <= (state_q == S_SHOW);
            done_q      <= (state_q == S_SHOW) && !show_seen_q;
            drop_q      <= in_calc && (key_digit || key_op || key_eq);

            // Display follows the state one cycle later and freezes during calculation.
            case (state_q)
                S_ENTER_A: begin
                    {disp_tens_q, disp_ones_q} <= a_q;
                    disp_hund_q <= 1'b0;
                    disp_neg_q  <= 1'b0;
                end
                S_ENTER_B: begin
                    {disp_tens_q, disp_ones_q} <= b_q;
                    disp_hund_q <= 1'b0;
                    disp_neg_q  <= 1'b0;
                end
                S_SHOW: begin
                    {disp_tens_q, disp_ones_q} <= res_q;
                    disp_hund_q <= hund_q;
                    disp_neg_q  <= neg_q;
                end
                default: ;
            endcase

            case (state_q)
                S_ENTER_A: begin
                    if (key_digit) begin
                        a_q <= {a_q[3:0], key_code};
                    end else if (key_op) begin
                        op_sub_q <= key_code[0];
                        b_q      <= 8'd0;
                        state_q  <= S_ENTER_B;
                    end else if (key_eq) begin
                        drop_q <= 1'b1;
                    end
                end
                S_ENTER_B: begin
                    if (key_digit) begin
                        b_q <= {b_q[3:0], key_code};
                    end else if (key_op) begin
                        op_sub_q <= key_code[0];
                    end else if (key_eq) begin
                        state_q <= S_CALC_LO;
                    end
                end
                S_CALC_LO: begin
                    res_q[3:0] <= dig_d;
                    cw_q       <= cout_d;
                    state_q    <= S_CALC_HI;
                end
                S_CALC_HI: begin
                    res_q[7:4] <= dig_d;
                    cw_q       <= cout_d;
                    if (op_sub_q && cout_d) begin
                        state_q <= S_FIX_LO;
                    end else begin
                        hund_q  <= !op_sub_q && cout_d;
                        neg_q   <= 1'b0;
                        state_q <= S_SHOW;
                    end
                end
                S_FIX_LO: begin
                    res_q[3:0] <= dig_d;
                    cw_q       <= cout_d;
                    state_q    <= S_FIX_HI;
                end
                S_FIX_HI: begin
                    res_q[7:4] <= dig_d;
                    hund_q     <= 1'b0;
                    neg_q      <= 1'b1;
                    state_q    <= S_SHOW;
                end
                S_SHOW: begin
                    if (key_digit) begin
                        a_q     <= {4'd0, key_code};
                        neg_q   <= 1'b0;
                        hund_q  <= 1'b0;
                        state_q <= S_ENTER_A;
                    end else if (key_op) begin
                        if (CHAIN_EN && !neg_q && !hund_q) begin
                            a_q      <= res_q;
                            op_sub_q <= key_code[0];
                            b_q      <= 8'd0;
                            state_q  <= S_ENTER_B;
                        end else begin
                            drop_q <= 1'b1;
                        end
                    end else if (key_eq) begin
                        drop_q <= 1'b1;
                    end
                end
                default: state_q <= S_ENTER_A;
            endcase
        end
    end

    assign disp_ones = disp_ones_q;
    assign disp_tens = disp_tens_q;
    assign disp_hund = disp_hund_q;
    assign disp_neg  = disp_neg_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign key_drop  = drop_q;
endmodule

// File: tb/tb_calc_seq_ctrl_v.sv
// Self-checking bench: directed test-plan scenarios plus random key streams
// against an integer-level model of the calculator.
module tb_calc_seq_ctrl_v;
    logic       CLK = 1'b0;
    logic       CLR = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic [3:0] disp_ones, disp_tens;
    logic       disp_hund, disp_neg, busy, done, key_drop;

    int errors = 0;
    int checks = 0;

    // Model: operands and result as plain integers; mode 0=A entry, 1=B entry, 2=result shown.
    int m_a, m_b, m_mag, m_mode;
    bit m_sub, m_neg, m_hund;

    calc_seq_ctrl_v #(.CHAIN_EN(1'b1)) dut (
        .CLK(CLK), .CLR(CLR), .key_valid(key_valid), .key_code(key_code),
        .disp_ones(disp_ones), .disp_tens(disp_tens), .disp_hund(disp_hund),
        .disp_neg(disp_neg), .busy(busy), .done(done), .key_drop(key_drop)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_a = 0; m_b = 0; m_mag = 0; m_mode = 0;
        m_sub = 0; m_neg = 0; m_hund = 0;
    endtask

    task automatic model_key(input int k, output bit drop, output int lat);
        drop = 0;
        lat  = 0;
        if (k == 13) begin
            model_reset();
        end else if (k <= 9) begin
            if (m_mode == 0)      m_a = (m_a % 10) * 10 + k;
            else if (m_mode == 1) m_b = (m_b % 10) * 10 + k;
            else begin m_a = k; m_mode = 0; m_neg = 0; m_hund = 0; end
        end else if (k == 10 || k == 11) begin
            if (m_mode == 0) begin
                m_sub = (k == 11); m_b = 0; m_mode = 1;
            end else if (m_mode == 1) begin
                m_sub = (k == 11);
            end else if (!m_neg && !m_hund) begin
                m_a = m_mag; m_sub = (k == 11); m_b = 0; m_mode = 1;
            end else begin
                drop = 1;
            end
        end else if (k == 12) begin
            if (m_mode == 1) begin
                m_mode = 2;
                if (!m_sub) begin
                    m_mag = m_a + m_b; m_neg = 0; m_hund = (m_mag >= 100); lat = 3;
                end else if (m_a >= m_b) begin
                    m_mag = m_a - m_b; m_neg = 0; m_hund = 0; lat = 3;
                end else begin
                    m_mag = m_b - m_a; m_neg = 1; m_hund = 0; lat = 5;
                end
            end else begin
                drop = 1;
            end
        end
    endtask

    task automatic chk_disp(input string tag);
        int v;
        bit h, n;
        v = (m_mode == 0) ? m_a : (m_mode == 1) ? m_b : (m_mag % 100);
        h = (m_mode == 2) ? m_hund : 1'b0;
        n = (m_mode == 2) ? m_neg : 1'b0;
        chk({tag, ".tens"}, 32'(disp_tens), 32'(v / 10));
        chk({tag, ".ones"}, 32'(disp_ones), 32'(v % 10));
        chk({tag, ".hund"}, 32'(disp_hund), 32'(h));
        chk({tag, ".neg"},  32'(disp_neg),  32'(n));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".outs"}, {20'd0, disp_ones, disp_tens, disp_hund, disp_neg, busy, done, key_drop}, 32'd0);
    endtask

    task automatic drive(input int k);
        key_valid = 1'b1;
        key_code  = 4'(k);
        @(negedge CLK);
        key_valid = 1'b0;
        key_code  = 4'd0;
    endtask

    task automatic wait_calc(input int lat, input int start);
        for (int cyc = start + 1; cyc <= lat; cyc++) begin
            @(negedge CLK);
            chk("calc.busy", 32'(busy), 32'(cyc < lat));
            chk("calc.done", 32'(done), 32'(cyc == lat));
        end
        chk_disp("calc.result");
    endtask

    task automatic press(input int k);
        bit d;
        int lat;
        model_key(k, d, lat);
        drive(k);
        chk("key.drop", 32'(key_drop), 32'(d));
        if (lat != 0) begin
            wait_calc(lat, 0);
        end else begin
            @(negedge CLK);
            chk("key.drop_pulse", 32'(key_drop), 32'd0);
            chk_disp("key.disp");
        end
        $display("key %0d -> disp %0d%0d hund=%0d neg=%0d drop=%0d", k, disp_tens, disp_ones,
                 disp_hund, disp_neg, d);
    endtask

    task automatic press_seq(input int ks[$]);
        foreach (ks[i]) press(ks[i]);
    endtask

    initial begin
        bit d;
        int lat;
        model_reset();
        repeat (3) @(negedge CLK);
        CLR = 1'b0;
        chk_all_zero("reset");
        @(negedge CLK);
        chk_disp("reset.disp");

        press_seq('{4, 7, 10, 5, 8, 12});       // 105
        press_seq('{13, 5, 8, 11, 2, 3, 12});   // 35
        press_seq('{13, 2, 3, 11, 5, 8, 12});   // -35 via fix pass
        press_seq('{13, 1, 2, 3, 11, 9, 9, 12});// -76
        press_seq('{13, 9, 9, 10, 9, 9, 12, 10, 12}); // 198, then dropped keys
        press_seq('{13, 1, 2, 10, 3, 12, 10, 4, 12}); // chain to 19
        press_seq('{14, 15, 5, 12});

        // Digit arriving while the calculation runs is dropped.
        press_seq('{13, 4, 10, 5});
        model_key(12, d, lat);
        drive(12);
        drive(7);
        chk("busy.drop", 32'(key_drop), 32'd1);
        chk("busy.busy", 32'(busy), 32'd1);
        wait_calc(lat, 1);
        $display("key 7 during busy -> disp %0d%0d", disp_tens, disp_ones);

        // CLEAR lands while the tens digit is being processed.
        press_seq('{13, 2, 10, 3});
        model_key(12, d, lat);
        drive(12);
        @(negedge CLK);
        chk("abort.busy", 32'(busy), 32'd1);
        drive(13);
        model_reset();
        chk_all_zero("abort");
        press(3);

        // Reset and key strobe together: reset wins.
        CLR = 1'b1; key_valid = 1'b1; key_code = 4'd5;
        @(negedge CLK);
        CLR = 1'b0; key_valid = 1'b0; key_code = 4'd0;
        model_reset();
        chk_all_zero("clr_key");
        @(negedge CLK);
        chk_disp("clr_key.disp");

        for (int n = 0; n < 200; n++) begin
            int r, k;
            r = int'($urandom_range(0, 99));
            if (r < 60)      k = int'($urandom_range(0, 9));
            else if (r < 72) k = 10;
            else if (r < 80) k = 11;
            else if (r < 92) k = 12;
            else if (r < 95) k = 13;
            else             k = int'($urandom_range(14, 15));
            press(k);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
